// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered hex word,
// blanking guard between digits, leading-zero suppression.
//
// Ports: clk, rst_n (async, active-low), enable, load, value_in,
// dp_in, lz_en -> nibble_out (to decoder), seg_in (from decoder),
// seg_out, an_n, dp_n (active-low pins), frame_tick (frame start).
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              nibble_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int VW   = 4 * NUM_DIGITS;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [VW-1:0]     shadow_v_q, shadow_v_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VW-1:0]     act_v_q, act_v_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic              pending_q, pending_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_tick_q, frame_tick_d;
  logic              blank_entry;
  logic              xfer;
  logic              lit_d;

  // Digit i is dark when it and every more-significant nibble is zero.
  function automatic logic is_supp(
    input logic [IW-1:0] i,
    input logic [VW-1:0] v,
    input logic          lz
  );
    logic upper_nz;
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(i) && v[4*j +: 4] != 4'h0) upper_nz = 1'b1;
    end
    return lz && (i != '0) && !upper_nz;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    blank_entry = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_BLANK;
          idx_d       = '0;
          cnt_d       = '0;
          blank_entry = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d     = ST_BLANK;
            cnt_d       = '0;
            idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            blank_entry = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Active word only changes between frames so a frame never tears.
    xfer = pending_q &&
           (state_q == ST_IDLE || (blank_entry && idx_d == '0));
    act_v_d     = xfer ? shadow_v_q  : act_v_q;
    act_dp_d    = xfer ? shadow_dp_q : act_dp_q;
    pending_d   = xfer ? 1'b0 : pending_q;
    shadow_v_d  = shadow_v_q;
    shadow_dp_d = shadow_dp_q;
    if (load) begin
      shadow_v_d  = value_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end

    // Decoder input moves only at BLANK entry so it settles unlit.
    nibble_d = blank_entry ? act_v_d[4*int'(idx_d) +: 4] : nibble_q;

    lit_d  = (state_d == ST_SHOW);
    an_n_d = '1;
    if (lit_d) an_n_d[idx_d] = 1'b0;
    dp_n_d = ~(lit_d && act_dp_d[idx_d] &&
               !is_supp(idx_d, act_v_d, lz_en));
    frame_tick_d = blank_entry && (idx_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_v_q   <= '0;
      shadow_dp_q  <= '0;
      act_v_q      <= '0;
      act_dp_q     <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= 4'h0;
      an_n_q       <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_v_q   <= shadow_v_d;
      shadow_dp_q  <= shadow_dp_d;
      act_v_q      <= act_v_d;
      act_dp_q     <= act_dp_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      an_n_q       <= an_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_out = (state_q == ST_SHOW &&
                    !is_supp(idx_q, act_v_q, lz_en)) ? seg_in : 7'h7F;

  assign nibble_out = nibble_q;
  assign an_n       = an_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: scenario tasks plus random traffic
// checked against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int DL    = BC + RD;
  localparam int FRAME = ND * DL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  nibble_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_tick;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: -1 = idle, else cycle position inside the frame.
  int          m_pos;
  logic [15:0] m_sh_v, m_act_v;
  logic [3:0]  m_sh_dp, m_act_dp;
  logic        m_pend;
  logic [3:0]  m_nib;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_tick;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .value_in  (value_in),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .nibble_out(nibble_out),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .an_n      (an_n),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  assign seg_in = dec7(nibble_out);

  task automatic model_reset();
    m_pos    = -1;
    m_sh_v   = '0;
    m_act_v  = '0;
    m_sh_dp  = '0;
    m_act_dp = '0;
    m_pend   = 1'b0;
    m_nib    = '0;
  endtask

  task automatic model_step();
    int old;
    old = m_pos;
    if (!enable) m_pos = -1;
    else if (m_pos < 0) m_pos = 0;
    else m_pos = (m_pos + 1) % FRAME;
    if (m_pend && (old < 0 || m_pos == 0)) begin
      m_act_v  = m_sh_v;
      m_act_dp = m_sh_dp;
      m_pend   = 1'b0;
    end
    if (load) begin
      m_sh_v  = value_in;
      m_sh_dp = dp_in;
      m_pend  = 1'b1;
    end
    if (m_pos >= 0)
      m_nib = 4'((m_act_v >> (4 * (m_pos / DL))) & 16'hF);
  endtask

  task automatic model_expect();
    int d;
    bit show, supp;
    if (m_pos < 0) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    end else begin
      d    = m_pos / DL;
      show = (m_pos % DL) >= BC;
      supp = lz_en && d != 0 && (m_act_v >> (4 * d)) == 16'h0;
      e_an   = show ? ~(4'b0001 << d) : 4'hF;
      e_seg  = (show && !supp) ? dec7(m_nib) : 7'h7F;
      e_dp   = !(show && !supp && m_act_dp[d]);
      e_tick = (m_pos == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    model_expect();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    value_in = '0; dp_in = '0; lz_en = 1'b0;
    model_reset();
    #12;
    n_chk += 5;
    if (an_n !== 4'hF) begin
      n_fail++; $display("FAIL rst_an: got %h want F", an_n);
    end
    if (seg_out !== 7'h7F) begin
      n_fail++; $display("FAIL rst_seg: got %h want 7F", seg_out);
    end
    if (dp_n !== 1'b1) begin
      n_fail++; $display("FAIL rst_dp: got %b want 1", dp_n);
    end
    if (frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL rst_tick: got %b want 0", frame_tick);
    end
    if (nibble_out !== 4'h0) begin
      n_fail++; $display("FAIL rst_nib: got %h want 0", nibble_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (an_n !== 4'hF) begin
        n_fail++; $display("FAIL idle_an: got %h want F", an_n);
      end
    end
  endtask

  task automatic test_scan();
    int ticks[$];
    logic [3:0] seq[$];
    logic [3:0] want[4];
    logic [3:0] prev_an;
    want = '{4'hF, 4'hA, 4'h2, 4'h1};
    value_in = 16'h12AF; dp_in = 4'b0101; load = 1'b1;
    step();
    load = 1'b0;
    enable = 1'b1;
    prev_an = 4'hF;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_chk += 5;
      if (an_n !== e_an) begin
        n_fail++; $display("FAIL scan_an: got %h want %h", an_n, e_an);
      end
      if (nibble_out !== m_nib) begin
        n_fail++;
        $display("FAIL scan_nib: got %h want %h", nibble_out, m_nib);
      end
      if (seg_out !== e_seg) begin
        n_fail++;
        $display("FAIL scan_seg: got %h want %h", seg_out, e_seg);
      end
      if (dp_n !== e_dp) begin
        n_fail++; $display("FAIL scan_dp: got %b want %b", dp_n, e_dp);
      end
      if (frame_tick !== e_tick) begin
        n_fail++;
        $display("FAIL scan_tick: got %b want %b", frame_tick, e_tick);
      end
      if (frame_tick === 1'b1) ticks.push_back(cyc);
      if (prev_an === 4'hF && an_n !== 4'hF) seq.push_back(nibble_out);
      prev_an = an_n;
    end
    n_chk++;
    if (ticks.size() != 2 || ticks[1] - ticks[0] != FRAME) begin
      n_fail++;
      $display("FAIL tick_period: got %0d ticks want 2 spaced %0d",
               ticks.size(), FRAME);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (seq.size() <= k || seq[k] !== want[k]) begin
        n_fail++;
        $display("FAIL nib_seq%0d: got %h want %h", k,
                 (seq.size() > k) ? seq[k] : 4'hx, want[k]);
      end
    end
  endtask

  task automatic test_no_tear();
    int seen3;
    seen3 = 0;
    for (int i = 0; i < 7; i++) step();
    value_in = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    value_in = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_chk += 2;
      if (nibble_out !== m_nib) begin
        n_fail++;
        $display("FAIL tear_nib: got %h want %h", nibble_out, m_nib);
      end
      if (an_n !== e_an) begin
        n_fail++; $display("FAIL tear_an: got %h want %h", an_n, e_an);
      end
      if (nibble_out === 4'h3) seen3++;
    end
    n_chk++;
    if (seen3 != 0) begin
      n_fail++; $display("FAIL tear_1234: got %0d want 0", seen3);
    end
  endtask

  task automatic test_lz();
    int lit, dpl, zeros;
    enable = 1'b0; lz_en = 1'b1;
    value_in = 16'h0005; dp_in = 4'b1000; load = 1'b1;
    step();
    load = 1'b0; enable = 1'b1;
    lit = 0; dpl = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_chk += 2;
      if (seg_out !== e_seg) begin
        n_fail++; $display("FAIL lz_seg: got %h want %h", seg_out, e_seg);
      end
      if (dp_n !== e_dp) begin
        n_fail++; $display("FAIL lz_dp: got %b want %b", dp_n, e_dp);
      end
      if (seg_out !== 7'h7F) lit++;
      if (dp_n === 1'b0) dpl++;
    end
    n_chk += 2;
    if (lit != 2 * RD) begin
      n_fail++; $display("FAIL lz_lit: got %0d want %0d", lit, 2 * RD);
    end
    if (dpl != 0) begin
      n_fail++; $display("FAIL lz_dpl: got %0d want 0", dpl);
    end
    value_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_chk++;
      if (seg_out !== e_seg) begin
        n_fail++; $display("FAIL lz0_seg: got %h want %h", seg_out, e_seg);
      end
    end
    zeros = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (seg_out === 7'h40) zeros++;
    end
    n_chk++;
    if (zeros != RD) begin
      n_fail++; $display("FAIL lz_zero: got %0d want %0d", zeros, RD);
    end
  endtask

  task automatic test_disable();
    int guard;
    enable = 1'b0; lz_en = 1'b0;
    value_in = 16'hBEEF; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0; enable = 1'b1;
    guard = 0;
    do begin
      step(); guard++;
    end while (m_pos != 2 * DL + BC + 1 && guard < 100);
    n_chk += 2;
    if (guard >= 100) begin
      n_fail++; $display("FAIL dis_reach: got timeout want digit2");
    end
    if (an_n !== 4'b1011) begin
      n_fail++; $display("FAIL dis_an2: got %h want B", an_n);
    end
    enable = 1'b0;
    step();
    n_chk += 2;
    if (an_n !== 4'hF) begin
      n_fail++; $display("FAIL dis_an: got %h want F", an_n);
    end
    if (seg_out !== 7'h7F) begin
      n_fail++; $display("FAIL dis_seg: got %h want 7F", seg_out);
    end
    step();
    enable = 1'b1;
    step();
    n_chk += 2;
    if (frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL dis_tick: got %b want 1", frame_tick);
    end
    if (nibble_out !== 4'hF) begin
      n_fail++; $display("FAIL dis_nib: got %h want F", nibble_out);
    end
    for (int i = 0; i < BC; i++) step();
    n_chk++;
    if (an_n !== 4'b1110) begin
      n_fail++; $display("FAIL dis_an0: got %h want E", an_n);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    do begin
      step(); guard++;
    end while (m_pos != DL + BC + 1 && guard < 100);
    n_chk++;
    if (an_n !== 4'b1101) begin
      n_fail++; $display("FAIL ar_pre: got %h want D", an_n);
    end
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    n_chk += 3;
    if (an_n !== 4'hF) begin
      n_fail++; $display("FAIL ar_an: got %h want F", an_n);
    end
    if (seg_out !== 7'h7F) begin
      n_fail++; $display("FAIL ar_seg: got %h want 7F", seg_out);
    end
    if (dp_n !== 1'b1) begin
      n_fail++; $display("FAIL ar_dp: got %b want 1", dp_n);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < FRAME + 1; i++) begin
      step();
      n_chk += 2;
      if (nibble_out !== 4'h0) begin
        n_fail++; $display("FAIL ar_nib: got %h want 0", nibble_out);
      end
      if (seg_out !== e_seg) begin
        n_fail++; $display("FAIL ar_seg2: got %h want %h", seg_out, e_seg);
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    value_in = 16'h4321; dp_in = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    guard = 0;
    while (m_pos != FRAME - 1 && guard < 100) begin
      step(); guard++;
    end
    value_in = 16'h8765; dp_in = 4'b0010; load = 1'b1;
    step();
    load = 1'b0;
    n_chk += 2;
    if (frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL b2b_tick: got %b want 1", frame_tick);
    end
    if (nibble_out !== 4'h1) begin
      n_fail++; $display("FAIL b2b_old: got %h want 1", nibble_out);
    end
    for (int i = 0; i < FRAME - 1; i++) begin
      step();
      n_chk += 2;
      if (nibble_out !== m_nib) begin
        n_fail++; $display("FAIL b2b_nib: got %h want %h", nibble_out, m_nib);
      end
      if (dp_n !== e_dp) begin
        n_fail++; $display("FAIL b2b_dp: got %b want %b", dp_n, e_dp);
      end
    end
    step();
    n_chk++;
    if (nibble_out !== 4'h5) begin
      n_fail++; $display("FAIL b2b_new: got %h want 5", nibble_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom);
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 2) == 0) value_in[15:8] = 8'h00;
      if ($urandom_range(0, 39) == 0) begin
        enable = ~enable;
        if (!enable) lz_en = 1'($urandom);
      end
      step();
      n_chk += 5;
      if (an_n !== e_an) begin
        n_fail++; $display("FAIL rnd_an: got %h want %h", an_n, e_an);
      end
      if (nibble_out !== m_nib) begin
        n_fail++; $display("FAIL rnd_nib: got %h want %h", nibble_out, m_nib);
      end
      if (seg_out !== e_seg) begin
        n_fail++; $display("FAIL rnd_seg: got %h want %h", seg_out, e_seg);
      end
      if (dp_n !== e_dp) begin
        n_fail++; $display("FAIL rnd_dp: got %b want %b", dp_n, e_dp);
      end
      if (frame_tick !== e_tick) begin
        n_fail++;
        $display("FAIL rnd_tick: got %b want %b", frame_tick, e_tick);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_no_tear();
    test_lz();
    test_disable();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
